// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the cache/memory-port path: arbiter FSM encoding and
// the default cache-line length that both caches and the arbiter agree on.
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t BUSY_I = 2'd1;
  localparam arb_state_t BUSY_D = 2'd2;
  localparam arb_state_t DONE   = 2'd3;

  localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index within one cache-line burst: cleared at grant, advanced on each
// memory ack, wrapping naturally since the line length is a power of two.
module burst_beat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int BURST_LEN = DEFAULT_BURST_LEN,
  localparam int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_o
);

  logic [BEAT_W-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between i-cache refills and d-cache refill or
// writeback bursts. ARB_ROUND_ROBIN_EN swaps fixed d-cache priority for alternation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int ADDR_W    = 30,
  parameter  int DATA_W    = 32,
  parameter  int BURST_LEN = DEFAULT_BURST_LEN,
  localparam int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic [BEAT_W-1:0] dc_beat_o,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Handshake: a requester holds req until its done pulse; each cycle with
  // mem_req_o and mem_ack_i high completes one beat, and address/data hold until then.
  arb_state_t               state_q, state_d;
  logic                     busy, start, take_dc, beat_adv, last_beat;
  logic [BEAT_W-1:0]        beat;
  logic [ADDR_W-BEAT_W-1:0] base_q;
  logic                     we_q, owner_dc_q, rvalid_q;
  logic [DATA_W-1:0]        rdata_q;
  logic                     unused_addr_bits;

  assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign start    = (state_q == IDLE) && (ic_req_i || dc_req_i);
  assign beat_adv = busy && mem_ack_i;
  assign unused_addr_bits = ^{ic_addr_i[BEAT_W-1:0], dc_addr_i[BEAT_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc_q;

  // On a tie, whoever was not served last goes next.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_dc_q <= 1'b0;
    end else if (start) begin
      last_dc_q <= take_dc;
    end
  end

  assign take_dc = dc_req_i && !(ic_req_i && last_dc_q);
`else
  assign take_dc = dc_req_i;
`endif

  burst_beat_counter #(.BURST_LEN(BURST_LEN)) u_beat (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start),
    .adv_i  (beat_adv),
    .beat_o (beat),
    .last_o (last_beat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (start) state_d = take_dc ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (beat_adv && last_beat) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q     <= '0;
      we_q       <= 1'b0;
      owner_dc_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (start) begin
        owner_dc_q <= take_dc;
        we_q       <= take_dc && dc_we_i;
        base_q     <= take_dc ? dc_addr_i[ADDR_W-1:BEAT_W] : ic_addr_i[ADDR_W-1:BEAT_W];
      end
      rvalid_q <= beat_adv && !we_q;
      if (beat_adv && !we_q) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  // Outputs decode the registered state only, so reset clears them at once.
  always_comb begin
    ic_gnt_o    = (state_q == BUSY_I);
    dc_gnt_o    = (state_q == BUSY_D);
    mem_req_o   = busy;
    mem_we_o    = busy && we_q;
    mem_addr_o  = busy ? {base_q, beat} : '0;
    mem_wdata_o = busy ? dc_wdata_i : '0;
    dc_beat_o   = beat;
    ic_done_o   = (state_q == DONE) && !owner_dc_q;
    dc_done_o   = (state_q == DONE) && owner_dc_q;
    ic_rvalid_o = rvalid_q && !owner_dc_q;
    dc_rvalid_o = rvalid_q && owner_dc_q;
    ic_rdata_o  = rdata_q;
    dc_rdata_o  = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cache requesters, a memory responder with
// selectable wait states, and a burst-level scoreboard.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 2;
  localparam int BW        = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic ic_req_i = 1'b0;
  logic [ADDR_W-1:0] ic_addr_i = '0;
  logic ic_gnt_o, ic_rvalid_o, ic_done_o;
  logic [DATA_W-1:0] ic_rdata_o;
  logic dc_req_i = 1'b0;
  logic dc_we_i = 1'b0;
  logic [ADDR_W-1:0] dc_addr_i = '0;
  logic [DATA_W-1:0] dc_wdata_i;
  logic [BEAT_W-1:0] dc_beat_o;
  logic dc_gnt_o, dc_rvalid_o, dc_done_o;
  logic [DATA_W-1:0] dc_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_beat_o(dc_beat_o), .dc_gnt_o(dc_gnt_o),
    .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference data ----------------
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0], 16'h5A00} ^ {2'b00, a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] wb_word(input logic [31:0] seed, input int k);
    return seed ^ (32'(k) * 32'h0101_0101);
  endfunction

  logic [31:0] wb_seed = 32'h0;
  assign dc_wdata_i = wb_word(wb_seed, int'(dc_beat_o));

  // ---------------- scoreboard state ----------------
  logic [ADDR_W-1:0] ic_pend_q[$];
  logic [ADDR_W:0]   dc_pend_q[$];
  logic [BW-1:0]     exp_q[$];
  logic [BW-1:0]     obs_q[$];
  logic [32:0]       exp_rd_q[$];
  logic [32:0]       obs_rd_q[$];
  bit                gnt_owner_q[$];
  int                gnt_cyc_q[$];
  int                dc_done_cyc = 0;
  int                n_ic_done = 0;
  int                n_dc_done = 0;
  int                ack_mode = 0;

  // Monitor: records every accepted beat, returned word and grant start.
  always begin : monitor
    bit prev_ic, prev_dc;
    @(negedge clk);
    if (mem_req_o && mem_ack_i)
      obs_q.push_back({mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0});
    if (ic_rvalid_o) obs_rd_q.push_back({1'b0, ic_rdata_o});
    if (dc_rvalid_o) obs_rd_q.push_back({1'b1, dc_rdata_o});
    if (ic_gnt_o && !prev_ic) begin gnt_owner_q.push_back(1'b0); gnt_cyc_q.push_back(cyc); end
    if (dc_gnt_o && !prev_dc) begin gnt_owner_q.push_back(1'b1); gnt_cyc_q.push_back(cyc); end
    prev_ic = ic_gnt_o;
    prev_dc = dc_gnt_o;
    if (ic_done_o) n_ic_done++;
    if (dc_done_o) begin n_dc_done++; dc_done_cyc = cyc; end
  end

  // Requesters and memory: act just after each rising edge.
  always begin : drivers
    bit ic_fin, dc_fin, tog;
    @(negedge clk);
    ic_fin = ic_done_o;
    dc_fin = dc_done_o;
    @(posedge clk);
    #1;
    if (!rst_i) begin
      if (ic_fin && ic_req_i) begin
        ic_req_i = 1'b0;
        if (ic_pend_q.size() > 0) void'(ic_pend_q.pop_front());
      end
      if (!ic_req_i && ic_pend_q.size() > 0) begin
        ic_addr_i = ic_pend_q[0];
        ic_req_i  = 1'b1;
      end
      if (dc_fin && dc_req_i) begin
        dc_req_i = 1'b0;
        if (dc_pend_q.size() > 0) void'(dc_pend_q.pop_front());
      end
      if (!dc_req_i && dc_pend_q.size() > 0) begin
        {dc_we_i, dc_addr_i} = dc_pend_q[0];
        dc_req_i = 1'b1;
      end
      case (ack_mode)
        0: mem_ack_i = mem_req_o;
        1: begin tog = !tog; mem_ack_i = mem_req_o && tog; end
        2: mem_ack_i = mem_req_o && ($urandom_range(0, 2) == 0);
        default: mem_ack_i = 1'b1;
      endcase
      mem_rdata_i = mem_word(mem_addr_o);
    end
  end

  // ---------------- model / driver helpers ----------------
  task automatic add_burst(input bit owner, input bit we, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < BURST_LEN; k++) begin
      a = (addr & ~ADDR_W'(BURST_LEN - 1)) + ADDR_W'(k);
      exp_q.push_back({we, a, we ? wb_word(wb_seed, k) : 32'h0});
      if (!we) exp_rd_q.push_back({owner, mem_word(a)});
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); exp_rd_q.delete(); obs_rd_q.delete();
    gnt_owner_q.delete(); gnt_cyc_q.delete();
    n_ic_done = 0; n_dc_done = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (ic_pend_q.size() == 0 && dc_pend_q.size() == 0 && !ic_req_i && !dc_req_i &&
          !mem_req_o && !ic_done_o && !dc_done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; ic_req_i = 1'b1; dc_req_i = 1'b1; mem_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ic_gnt_o, dc_gnt_o, mem_req_o, mem_we_o} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {ic_gnt_o, dc_gnt_o, mem_req_o, mem_we_o});
    end
    checks++;
    if ({ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o} !== 4'b0) begin
      errors++; $display("FAIL reset_status: got %b want 0000", {ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, dc_beat_o} !== '0) begin
      errors++; $display("FAIL reset_bus: addr %h wdata %h beat %0d want 0", mem_addr_o, mem_wdata_o, dc_beat_o);
    end
    checks++;
    if ({ic_rdata_o, dc_rdata_o} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h %h want 0", ic_rdata_o, dc_rdata_o);
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ic_gnt_o, dc_gnt_o, mem_req_o} !== 3'b0) begin
      errors++; $display("FAIL reset_idle: got %b want 000", {ic_gnt_o, dc_gnt_o, mem_req_o});
    end
  endtask

  task automatic test_ic_refill();
    bit exp_gnt, exp_rv, exp_done;
    logic [ADDR_W-1:0] exp_addr;
    ack_mode = 0;
    ic_pend_q.push_back(30'h100);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_gnt  = (k >= 1 && k <= BURST_LEN);
      exp_rv   = (k >= 2 && k <= BURST_LEN + 1);
      exp_done = (k == BURST_LEN + 1);
      exp_addr = exp_gnt ? 30'h100 + ADDR_W'(k - 1) : '0;
      checks++;
      if ({ic_gnt_o, mem_req_o, dc_gnt_o} !== {exp_gnt, exp_gnt, 1'b0}) begin
        errors++; $display("FAIL ic_grant c%0d: got %b want %b", k, {ic_gnt_o, mem_req_o, dc_gnt_o}, {exp_gnt, exp_gnt, 1'b0});
      end
      checks++;
      if (mem_addr_o !== exp_addr) begin
        errors++; $display("FAIL ic_addr c%0d: got %h want %h", k, mem_addr_o, exp_addr);
      end
      checks++;
      if ({ic_rvalid_o, dc_rvalid_o} !== {exp_rv, 1'b0}) begin
        errors++; $display("FAIL ic_rvalid c%0d: got %b want %b", k, {ic_rvalid_o, dc_rvalid_o}, {exp_rv, 1'b0});
      end
      if (exp_rv) begin
        checks++;
        if (ic_rdata_o !== mem_word(30'h100 + ADDR_W'(k - 2))) begin
          errors++; $display("FAIL ic_rdata c%0d: got %h want %h", k, ic_rdata_o, mem_word(30'h100 + ADDR_W'(k - 2)));
        end
      end
      checks++;
      if ({ic_done_o, dc_done_o, mem_we_o} !== {exp_done, 2'b00}) begin
        errors++; $display("FAIL ic_done c%0d: got %b want %b", k, {ic_done_o, dc_done_o, mem_we_o}, {exp_done, 2'b00});
      end
    end
  endtask

  task automatic test_tie();
    bit ok;
    bit exp_own[$];
    logic [ADDR_W-1:0] ia, da;
    bit dwe;
    ack_mode = 0;
    clear_sb();
    wb_seed = $urandom;
`ifdef ARB_ROUND_ROBIN_EN
    for (int n = 0; n < 2; n++) begin
      ia = ADDR_W'($urandom); da = ADDR_W'($urandom); dwe = 1'($urandom_range(0, 1));
      ic_pend_q.push_back(ia);
      dc_pend_q.push_back({dwe, da});
      add_burst(1'b1, dwe, da); exp_own.push_back(1'b1);
      add_burst(1'b0, 1'b0, ia); exp_own.push_back(1'b0);
    end
`else
    ia = ADDR_W'($urandom); da = ADDR_W'($urandom); dwe = 1'($urandom_range(0, 1));
    ic_pend_q.push_back(ia);
    dc_pend_q.push_back({dwe, da});
    add_burst(1'b1, dwe, da); exp_own.push_back(1'b1);
    add_burst(1'b0, 1'b0, ia); exp_own.push_back(1'b0);
`endif
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tie_timeout: got busy want idle"); end
    checks++;
    if (gnt_owner_q.size() != exp_own.size()) begin
      errors++; $display("FAIL tie_grants: got %0d want %0d", gnt_owner_q.size(), exp_own.size());
    end
    for (int i = 0; i < exp_own.size() && i < gnt_owner_q.size(); i++) begin
      checks++;
      if (gnt_owner_q[i] !== exp_own[i]) begin
        errors++; $display("FAIL tie_order[%0d]: got %0d want %0d (1=dcache)", i, gnt_owner_q[i], exp_own[i]);
      end
    end
`ifndef ARB_ROUND_ROBIN_EN
    checks++;
    if (gnt_cyc_q.size() < 2 || gnt_cyc_q[1] != dc_done_cyc + 2) begin
      errors++; $display("FAIL tie_igap: got %0d want %0d", gnt_cyc_q.size() < 2 ? -1 : gnt_cyc_q[1], dc_done_cyc + 2);
    end
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tie_beats: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL tie_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_rd_q != exp_rd_q) begin
      errors++; $display("FAIL tie_rdata: got %0d words want %0d", obs_rd_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_dc_writeback();
    bit ok;
    ack_mode = 1;
    clear_sb();
    wb_seed = $urandom;
    dc_pend_q.push_back({1'b1, 30'h207});
    add_burst(1'b1, 1'b1, 30'h207);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wb_timeout: got busy want idle"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wb_beats: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wb_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_rd_q.size() != 0) begin
      errors++; $display("FAIL wb_rvalid: got %0d words want 0", obs_rd_q.size());
    end
    checks++;
    if (n_dc_done != 1 || n_ic_done != 0) begin
      errors++; $display("FAIL wb_done: got dc %0d ic %0d want 1 0", n_dc_done, n_ic_done);
    end
  endtask

  task automatic test_stray_ack();
    bit ok;
    logic [ADDR_W-1:0] ia;
    ack_mode = 3;
    clear_sb();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, dc_beat_o} !== '0) begin
        errors++; $display("FAIL stray_idle c%0d: got req %b rv %b beat %0d want 0", k, mem_req_o, ic_rvalid_o | dc_rvalid_o, dc_beat_o);
      end
    end
    ia = ADDR_W'($urandom);
    ic_pend_q.push_back(ia);
    add_burst(1'b0, 1'b0, ia);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL stray_timeout: got busy want idle"); end
    checks++;
    if (obs_q != exp_q) begin
      errors++; $display("FAIL stray_beats: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_rd_q != exp_rd_q) begin
      errors++; $display("FAIL stray_rdata: got %0d words want %0d", obs_rd_q.size(), exp_rd_q.size());
    end
    checks++;
    if (dc_beat_o !== '0 || n_ic_done != 1) begin
      errors++; $display("FAIL stray_after: got beat %0d done %0d want 0 1", dc_beat_o, n_ic_done);
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok, found;
    logic [ADDR_W-1:0] ia;
    ack_mode = 0;
    ic_pend_q.push_back(ADDR_W'($urandom));
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req_o && mem_addr_o[1:0] == 2'd2) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_mid_reach: got no beat 2 want beat 2"); end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b want 0000000",
        {mem_req_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o});
    end
    ic_pend_q.delete(); dc_pend_q.delete();
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    clear_sb();
    ia = ADDR_W'($urandom);
    ic_pend_q.push_back(ia);
    add_burst(1'b0, 1'b0, ia);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got busy want idle"); end
    checks++;
    if (obs_q != exp_q) begin
      errors++; $display("FAIL rst_mid_restart: got first %h want %h", obs_q.size() > 0 ? obs_q[0] : '0, exp_q[0]);
    end
    checks++;
    if (obs_rd_q != exp_rd_q) begin
      errors++; $display("FAIL rst_mid_rdata: got %0d words want %0d", obs_rd_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_random();
    bit ok, own, we;
    logic [ADDR_W-1:0] a;
    int exp_ic, exp_dc;
    clear_sb();
    exp_ic = 0; exp_dc = 0;
    for (int n = 0; n < 16; n++) begin
      ack_mode = $urandom_range(0, 2);
      wb_seed = $urandom;
      own = 1'($urandom_range(0, 1));
      we = own && ($urandom_range(0, 1) == 1);
      a = ADDR_W'($urandom);
      if (own) begin dc_pend_q.push_back({we, a}); exp_dc++; end
      else begin ic_pend_q.push_back(a); exp_ic++; end
      add_burst(own, we, a);
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: got busy want idle", n); end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_beats: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_rd_q.size() != exp_rd_q.size()) begin
      errors++; $display("FAIL rand_rcount: got %0d want %0d", obs_rd_q.size(), exp_rd_q.size());
    end
    for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++) begin
      checks++;
      if (obs_rd_q[i] !== exp_rd_q[i]) begin
        errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, obs_rd_q[i], exp_rd_q[i]);
      end
    end
    checks++;
    if (n_ic_done != exp_ic || n_dc_done != exp_dc) begin
      errors++; $display("FAIL rand_done: got ic %0d dc %0d want %0d %0d", n_ic_done, n_dc_done, exp_ic, exp_dc);
    end
  endtask

  initial begin
    test_reset();
    test_ic_refill();
    test_tie();
    test_dc_writeback();
    test_stray_ack();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
